// File: rtl/multiport_register_file_pkg.sv
// multiport_register_file_pkg: shared state encoding and default parameters for the register file
//    Contents: state_t {CLEAR, RUN}; DEF_DATA_W, DEF_ADDR_W, DEF_NUM_RD, DEF_NUM_WR
package multiport_register_file_pkg;
   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 3;
   localparam int DEF_NUM_WR = 2;
endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// regfile_scoreboard: per-register pending bits with clear, write-release, alloc-set and read lookup
//    Ports: clk; clr_en/clr_addr zero one bit per cycle; wr_en/wr_addr release pending;
//           alloc_en/alloc_addr set pending; rd_addr -> rd_pending lookup (address 0 never pending)
module regfile_scoreboard
   import multiport_register_file_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD,
   parameter int NUM_WR = DEF_NUM_WR
) (
   input  logic                     clk,
   input  logic                     clr_en,
   input  logic [ADDR_W-1:0]        clr_addr,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic                     alloc_en,
   input  logic [ADDR_W-1:0]        alloc_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_pending
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DEPTH-1:0] pend;
   // alloc is applied after the write releases so a same-cycle alloc leaves the bit set
   always_ff @(posedge clk) begin
      if (clr_en) pend[clr_addr] <= 1'b0;
      else begin
         for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j] && |wr_addr[j*ADDR_W +: ADDR_W]) pend[wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
         if (alloc_en && |alloc_addr) pend[alloc_addr] <= 1'b1;
      end
   end
   always_comb begin
      rd_pending = '0;
      for (int k = 0; k < NUM_RD; k++)
         rd_pending[k] = |rd_addr[k*ADDR_W +: ADDR_W] && pend[rd_addr[k*ADDR_W +: ADDR_W]];
   end
endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: multi-read/multi-write register file with sequential clear and pending scoreboard
//    Ports: clk, reset_n (async active-low), clear_req, ready;
//           rd_addr/rd_data/rd_pending per read port; wr_en/wr_addr/wr_data per write port; alloc_en/alloc_addr
//    Macro: MULTIPORT_REGISTER_FILE_BYPASS_EN forwards same-cycle write data to matching reads
module multiport_register_file
   import multiport_register_file_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD,
   parameter int NUM_WR = DEF_NUM_WR
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear_req,
   output logic                     ready,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_pending,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     alloc_en,
   input  logic [ADDR_W-1:0]        alloc_addr
);
   localparam int DEPTH = 2**ADDR_W;
   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic              run;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [NUM_RD-1:0] sb_pending;
   assign run   = (state == RUN);
   assign ready = run;
   // clearing finishes on the edge that zeroes the last register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= CLEAR;
         cnt   <= '0;
      end else if (clear_req) begin
         state <= CLEAR;
         cnt   <= '0;
      end else if (!run) begin
         cnt <= cnt + 1'b1;
         if (&cnt) state <= RUN;
      end
   end
   // later ports overwrite earlier ones, so the highest-indexed port wins a collision
   always_ff @(posedge clk) begin
      if (!run) mem[cnt] <= '0;
      else
         for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j] && |wr_addr[j*ADDR_W +: ADDR_W])
               mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
   end
   regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) u_sb (
      .clk        (clk),
      .clr_en     (!run),
      .clr_addr   (cnt),
      .wr_en      (wr_en & {NUM_WR{run}}),
      .wr_addr    (wr_addr),
      .alloc_en   (alloc_en & run),
      .alloc_addr (alloc_addr),
      .rd_addr    (rd_addr),
      .rd_pending (sb_pending)
   );
   assign rd_pending = sb_pending & {NUM_RD{run}};
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      assign a = rd_addr[k*ADDR_W +: ADDR_W];
      always_comb begin
         d = mem[a];
`ifdef MULTIPORT_REGISTER_FILE_BYPASS_EN
         for (int j = 0; j < NUM_WR; j++)
            if (run && wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == a) d = wr_data[j*DATA_W +: DATA_W];
`endif
      end
      assign rd_data[k*DATA_W +: DATA_W] = (run && |a) ? d : '0;
   end
endmodule

// File: tb/tb_multiport_register_file.sv
// tb_multiport_register_file: table-driven, directed and randomized checks against a behavioural model
module tb_multiport_register_file;
`ifdef MULTIPORT_REGISTER_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        clear_req = 1'b0;
   logic        ready;
   logic [14:0] rd_addr = '0;
   logic [95:0] rd_data;
   logic [2:0]  rd_pending;
   logic [1:0]  wr_en = '0;
   logic [9:0]  wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic        alloc_en = 1'b0;
   logic [4:0]  alloc_addr = '0;

   multiport_register_file dut (
      .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .ready(ready),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference: register contents, pending flags, edges left until ready
   logic [31:0] m_mem [32];
   bit          m_pend [32];
   int          rem = 32;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic m_zero();
      for (int i = 0; i < 32; i++) begin
         m_mem[i] = '0;
         m_pend[i] = 1'b0;
      end
      rem = 32;
   endtask

   function automatic logic [31:0] exp_rd(input int k);
      int a = int'(rd_addr[k*5 +: 5]);
      logic [31:0] v;
      if (rem != 0 || a == 0) return '0;
      v = m_mem[a];
      if (BYP)
         for (int j = 0; j < 2; j++)
            if (wr_en[j] && int'(wr_addr[j*5 +: 5]) == a) v = wr_data[j*32 +: 32];
      return v;
   endfunction

   function automatic logic exp_pend(input int k);
      int a = int'(rd_addr[k*5 +: 5]);
      return rem == 0 && a != 0 && m_pend[a];
   endfunction

   task automatic m_edge();
      if (!reset_n) m_zero();
      else if (rem != 0) begin
         if (clear_req) rem = 32;
         else rem--;
      end else if (clear_req) m_zero();
      else begin
         for (int j = 0; j < 2; j++) begin
            int a = int'(wr_addr[j*5 +: 5]);
            if (wr_en[j] && a != 0) begin
               m_mem[a] = wr_data[j*32 +: 32];
               m_pend[a] = 1'b0;
            end
         end
         if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
      end
   endtask

   // inputs are set at the negedge; outputs checked 1 time unit later, then the edge is modelled
   task automatic step();
      if (!reset_n) m_zero();
      #1;
      chk("ready", {31'b0, ready}, {31'b0, rem == 0});
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rd_data[%0d]", k), rd_data[k*32 +: 32], exp_rd(k));
         chk($sformatf("rd_pending[%0d]", k), {31'b0, rd_pending[k]}, {31'b0, exp_pend(k)});
      end
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en = '0;
      alloc_en = 1'b0;
      clear_req = 1'b0;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 32; i++) begin
         #1 chk("ready_low", {31'b0, ready}, 32'd0);
         step();
      end
      #1 chk("ready_high", {31'b0, ready}, 32'd1);
   endtask

   task automatic sweep_zero();
      for (int a = 1; a < 32; a++) begin
         rd_addr = {3{a[4:0]}};
         #1 chk("swept_zero", rd_data[31:0], 32'd0);
         step();
      end
   endtask

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic        al;
      logic [4:0]  aa, ra;
      logic [31:0] ed;
      logic        ep;
   } vec_t;
   vec_t tbl [13];

   initial begin
      tbl[0]  = '{2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'h12345678, 1'b0, 5'd0, 5'd5, BYP ? 32'h12345678 : 32'h0, 1'b0};
      tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 32'h12345678, 1'b0};
      tbl[2]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd0, 5'd0, 32'h0, 1'b0};
      tbl[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0};
      tbl[4]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 32'h0, 1'b0};
      tbl[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 32'h0, 1'b1};
      tbl[6]  = '{2'b01, 5'd7, 5'd0, 32'h11111111, 32'h0, 1'b0, 5'd0, 5'd7, BYP ? 32'h11111111 : 32'h0, 1'b1};
      tbl[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 32'h11111111, 1'b0};
      tbl[8]  = '{2'b10, 5'd0, 5'd9, 32'h0, 32'h99999999, 1'b1, 5'd9, 5'd9, BYP ? 32'h99999999 : 32'h0, 1'b0};
      tbl[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 32'h99999999, 1'b1};
      tbl[10] = '{2'b01, 5'd3, 5'd0, 32'h33333333, 32'h0, 1'b0, 5'd0, 5'd3, BYP ? 32'h33333333 : 32'h0, 1'b0};
      tbl[11] = '{2'b01, 5'd3, 5'd0, 32'hA5A5A5A5, 32'h0, 1'b0, 5'd0, 5'd3, BYP ? 32'hA5A5A5A5 : 32'h33333333, 1'b0};
      tbl[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 32'hA5A5A5A5, 1'b0};

      m_zero();
      @(negedge clk);
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      wait_ready();
      sweep_zero();

      for (int i = 0; i < 13; i++) begin
         wr_en = tbl[i].we;
         wr_addr = {tbl[i].wa1, tbl[i].wa0};
         wr_data = {tbl[i].wd1, tbl[i].wd0};
         alloc_en = tbl[i].al;
         alloc_addr = tbl[i].aa;
         rd_addr = {5'd0, 5'd0, tbl[i].ra};
         #1;
         chk($sformatf("vec%0d_data", i), rd_data[31:0], tbl[i].ed);
         chk($sformatf("vec%0d_pend", i), {31'b0, rd_pending[0]}, {31'b0, tbl[i].ep});
         step();
      end
      idle();

      for (int a = 1; a < 32; a++) begin
         wr_en = 2'b01;
         wr_addr = {5'd0, a[4:0]};
         wr_data = {32'h0, $urandom() | 32'h1};
         step();
      end
      idle();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 10; i++) step();
      reset_n = 1'b0;
      #1 chk("reset_mid_clear_ready", {31'b0, ready}, 32'd0);
      step();
      reset_n = 1'b1;
      wait_ready();
      sweep_zero();

      for (int c = 0; c < 1500; c++) begin
         wr_en = 2'($urandom());
         for (int j = 0; j < 2; j++) begin
            wr_addr[j*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom());
            wr_data[j*32 +: 32] = $urandom();
         end
         alloc_en = ($urandom_range(0, 3) == 0);
         alloc_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom());
         for (int k = 0; k < 3; k++)
            rd_addr[k*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom());
         clear_req = ($urandom_range(0, 199) == 0);
         reset_n = ($urandom_range(0, 499) != 0);
         step();
      end
      idle();
      reset_n = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
